// File: rtl/cray_mem_pkg.sv
// cray_mem_pkg
// Shared constants and types for the Cray-1 main-memory arbiter slice.
//   CRAY_ADDR_W / CRAY_WORD_W : default word-address and word widths
//   ARB_FIXED / ARB_RR        : arbitration policy selectors
//   mem_tag_t                 : read-return tag {vld, port_id}
//   next_port()               : wrap-around successor of a port index
package cray_mem_pkg;

  localparam int unsigned CRAY_ADDR_W  = 22;
  localparam int unsigned CRAY_WORD_W  = 64;

  localparam int unsigned ARB_FIXED    = 0;
  localparam int unsigned ARB_RR       = 1;

  localparam int unsigned PORT_ID_W    = 3;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef struct packed {
    logic                 vld;
    logic [PORT_ID_W-1:0] port_id;
  } mem_tag_t;

  // (k + 1) mod n for a port index k < n
  function automatic logic [PORT_ID_W-1:0] next_port(input logic [PORT_ID_W-1:0] k,
                                                     input int unsigned          n);
    if (32'(k) + 1 >= n) return '0;
    return k + 1'b1;
  endfunction

endpackage

// File: rtl/cray_mem_arb_pick.sv
// cray_mem_arb_pick
// Combinational rotating-priority one-hot picker. The search begins at
// port `start` and wraps from NUM_PORTS-1 back to 0; the first requesting
// port wins. A start of 0 gives plain fixed priority.
//   req    in  NUM_PORTS  request vector
//   start  in  3          highest-priority port index
//   gnt    out NUM_PORTS  one-hot grant (0 when no request)
//   gnt_id out 3          index of the granted port
//   any    out 1          a port was granted
module cray_mem_arb_pick
  import cray_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_ID_W-1:0] start,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_ID_W-1:0] gnt_id,
  output logic                 any
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W-1:0] sel;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sel    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      sel = IDX_W'((32'(start) + i) % NUM_PORTS);
      if (!any && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_id   = PORT_ID_W'(sel);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cray_mem_arb.sv
// cray_mem_arb
// Shares the single Cray-1 main-memory port between NUM_PORTS requesters.
// Grant is combinational (fixed priority or round robin); the memory bus is
// muxed from the granted port; a RD_LAT-deep tag pipeline routes each read's
// valid strobe back to the port that issued it.
// Optional starvation guard: define CRAY_MEM_ARB_STARVE_GUARD_EN to add a
// 4-bit saturating wait counter per port; any requester whose count has
// reached STARVE_LIMIT preempts the policy (lowest index first).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_req/i_wr_en         per-port request / write flag (0 = read)
//   i_addr/i_wr_data      per-port address / write data, port k at [k*W +: W]
//   o_gnt                 one-hot grant, same cycle as request
//   o_rd_vld/o_rd_data    one-hot read-return strobe / broadcast read data
//   o_mem_*               memory address, write data, write enable, chip enable
//   i_mem_rd_data/i_mem_vld  memory read data and valid
module cray_mem_arb
  import cray_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned ADDR_W       = CRAY_ADDR_W,
  parameter int unsigned DATA_W       = CRAY_WORD_W,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned ARB_MODE     = ARB_FIXED,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        i_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_addr,
  input  logic [NUM_PORTS-1:0]        i_wr_en,
  input  logic [NUM_PORTS*DATA_W-1:0] i_wr_data,
  output logic [NUM_PORTS-1:0]        o_gnt,
  output logic [NUM_PORTS-1:0]        o_rd_vld,
  output logic [DATA_W-1:0]           o_rd_data,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wr_data,
  output logic                        o_mem_wr_en,
  output logic                        o_mem_ce,
  input  logic [DATA_W-1:0]           i_mem_rd_data,
  input  logic                        i_mem_vld
);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || RD_LAT < 1 || RD_LAT > 8 ||
      STARVE_LIMIT > (2**STARVE_CNT_W) - 1) begin : g_bad_param
    $error("cray_mem_arb: parameter out of range");
  end

  logic [PORT_ID_W-1:0] rr_ptr;
  logic [PORT_ID_W-1:0] start;
  logic [NUM_PORTS-1:0] pol_gnt;
  logic [PORT_ID_W-1:0] pol_id;
  logic                 pol_any;

  logic [NUM_PORTS-1:0] gnt;
  logic [PORT_ID_W-1:0] win_id;
  logic                 win_any;
  logic                 win_wr;

  mem_tag_t             tag_pipe [RD_LAT];
  mem_tag_t             tag_last;

  assign start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  cray_mem_arb_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_policy (
    .req    (i_req),
    .start  (start),
    .gnt    (pol_gnt),
    .gnt_id (pol_id),
    .any    (pol_any)
  );

`ifdef CRAY_MEM_ARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] wait_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0]    starved;
  logic [NUM_PORTS-1:0]    stv_gnt;
  logic [PORT_ID_W-1:0]    stv_id;
  logic                    stv_any;

  // Only ports still requesting may preempt, so the grant stays a subset of i_req.
  always_comb begin
    starved = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++)
      starved[k] = i_req[k] && (32'(wait_cnt[k]) >= STARVE_LIMIT);
  end

  cray_mem_arb_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_starve (
    .req    (starved),
    .start  ('0),
    .gnt    (stv_gnt),
    .gnt_id (stv_id),
    .any    (stv_any)
  );

  always_comb begin
    gnt     = stv_any ? stv_gnt : pol_gnt;
    win_id  = stv_any ? stv_id  : pol_id;
    win_any = stv_any | pol_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) wait_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (gnt[k])
          wait_cnt[k] <= '0;
        else if (i_req[k] && (wait_cnt[k] != '1))
          wait_cnt[k] <= wait_cnt[k] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt     = pol_gnt;
    win_id  = pol_id;
    win_any = pol_any;
  end
`endif

  assign o_gnt    = gnt;
  assign o_mem_ce = |i_req;

  always_comb begin
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    o_mem_wr_en   = 1'b0;
    win_wr        = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (gnt[k]) begin
        o_mem_addr    = i_addr[k*ADDR_W +: ADDR_W];
        o_mem_wr_data = i_wr_data[k*DATA_W +: DATA_W];
        o_mem_wr_en   = i_wr_en[k];
        win_wr        = i_wr_en[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (win_any)
      rr_ptr <= next_port(win_id, NUM_PORTS);
  end

  // Stage 0 always takes the winner id; only vld distinguishes a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{vld: win_any && !win_wr, port_id: win_id};
      for (int unsigned i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_last  = tag_pipe[RD_LAT-1];
  assign o_rd_data = i_mem_rd_data;

  always_comb begin
    o_rd_vld = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++)
      o_rd_vld[k] = i_mem_vld && tag_last.vld && (tag_last.port_id == PORT_ID_W'(k));
  end

endmodule

// File: tb/tb_cray_mem_arb.sv
// tb_cray_mem_arb
// Two 4-port arbiters share one stimulus stream: u_fp (fixed priority,
// RD_LAT=3) and u_rr (round robin, RD_LAT=1), both with STARVE_LIMIT=3.
// A per-cycle reference model (grant rules, per-cycle read history indexed
// by cycle number, wait counters) predicts every output.
// The guard model is active when CRAY_MEM_ARB_STARVE_GUARD_EN is defined.
module tb_cray_mem_arb;

  localparam int NP     = 4;
  localparam int AW     = 22;
  localparam int DW     = 64;
  localparam int LAT_FP = 3;
  localparam int LAT_RR = 1;
  localparam int SL     = 3;
  localparam int MAXC   = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req;
  logic [NP-1:0]     wr;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [DW-1:0]     mrd;
  logic              mvld;

  logic [NP-1:0] gnt_f, rdv_f, gnt_r, rdv_r;
  logic [DW-1:0] rdd_f, mwd_f, rdd_r, mwd_r;
  logic [AW-1:0] maddr_f, maddr_r;
  logic          mwe_f, mce_f, mwe_r, mce_r;

  always #5 clk = ~clk;

  cray_mem_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_FP),
                 .ARB_MODE(0), .STARVE_LIMIT(SL)) u_fp (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_addr(addr), .i_wr_en(wr),
    .i_wr_data(wdata), .o_gnt(gnt_f), .o_rd_vld(rdv_f), .o_rd_data(rdd_f),
    .o_mem_addr(maddr_f), .o_mem_wr_data(mwd_f), .o_mem_wr_en(mwe_f),
    .o_mem_ce(mce_f), .i_mem_rd_data(mrd), .i_mem_vld(mvld));

  cray_mem_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_RR),
                 .ARB_MODE(1), .STARVE_LIMIT(SL)) u_rr (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_addr(addr), .i_wr_en(wr),
    .i_wr_data(wdata), .o_gnt(gnt_r), .o_rd_vld(rdv_r), .o_rd_data(rdd_r),
    .o_mem_addr(maddr_r), .o_mem_wr_data(mwd_r), .o_mem_wr_en(mwe_r),
    .o_mem_ce(mce_r), .i_mem_rd_data(mrd), .i_mem_vld(mvld));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int floor_c = 0;
  int ptr = 0;
  int wcnt [2][NP];
  int hist [2][MAXC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input int d, input logic [NP-1:0] r);
`ifdef CRAY_MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < NP; k++) if (r[k] && wcnt[d][k] >= SL) return k;
`endif
    for (int i = 0; i < NP; i++) begin
      int k;
      k = (d == 0) ? i : (ptr + i) % NP;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic rand_bus();
    for (int k = 0; k < NP; k++) begin
      addr[k*AW +: AW]  = AW'($urandom);
      wdata[k*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, then advance the model.
  task automatic do_cycle(input bit rst, input logic [NP-1:0] r, input logic [NP-1:0] w,
                          input bit mv, input logic [DW-1:0] md);
    @(negedge clk);
    rst_n = !rst; req = r; wr = w; mvld = mv; mrd = md;
    #1;
    if (rst) begin
      floor_c = cyc + 1;
      ptr = 0;
      for (int d = 0; d < 2; d++) for (int k = 0; k < NP; k++) wcnt[d][k] = 0;
    end
    for (int d = 0; d < 2; d++) begin
      int win, lat, src;
      string p;
      logic [NP-1:0] e_gnt, e_rdv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic          e_we;
      win = model_pick(d, r);
      lat = (d == 0) ? LAT_FP : LAT_RR;
      p   = (d == 0) ? "fp" : "rr";
      e_gnt = '0; e_addr = '0; e_wd = '0; e_we = 1'b0; e_rdv = '0;
      if (win >= 0) begin
        e_gnt[win] = 1'b1;
        e_addr = addr[win*AW +: AW];
        e_wd   = wdata[win*DW +: DW];
        e_we   = w[win];
      end
      src = cyc - lat;
      if (mv && src >= floor_c && src >= 0 && hist[d][src] >= 0) e_rdv[hist[d][src]] = 1'b1;
      check({p, "_gnt"},   (d == 0) ? 64'(gnt_f)   : 64'(gnt_r),   64'(e_gnt));
      check({p, "_rdvld"}, (d == 0) ? 64'(rdv_f)   : 64'(rdv_r),   64'(e_rdv));
      check({p, "_rddat"}, (d == 0) ? 64'(rdd_f)   : 64'(rdd_r),   64'(md));
      check({p, "_addr"},  (d == 0) ? 64'(maddr_f) : 64'(maddr_r), 64'(e_addr));
      check({p, "_wdat"},  (d == 0) ? 64'(mwd_f)   : 64'(mwd_r),   64'(e_wd));
      check({p, "_we"},    (d == 0) ? 64'(mwe_f)   : 64'(mwe_r),   64'(e_we));
      check({p, "_ce"},    (d == 0) ? 64'(mce_f)   : 64'(mce_r),   64'(|r));
      hist[d][cyc] = (!rst && win >= 0 && !w[win]) ? win : -1;
      if (!rst) begin
        if (d == 1 && win >= 0) ptr = (win + 1) % NP;
        for (int k = 0; k < NP; k++) begin
          if (win == k) wcnt[d][k] = 0;
          else if (r[k] && wcnt[d][k] < 15) wcnt[d][k]++;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    logic [NP-1:0] rr_exp [5];
    logic [NP-1:0] tag_exp [3];
    rst_n = 1'b0; req = '0; wr = '0; mvld = 1'b0; mrd = '0; addr = '0; wdata = '0;

    // Reset state
    do_cycle(1, 4'b0000, 4'b0000, 0, '0);
    check("rst_gnt_f", 64'(gnt_f), 64'(0));
    check("rst_ce_f", 64'(mce_f), 64'(0));
    check("rst_rrptr", 64'(u_rr.rr_ptr), 64'(0));

    // Fixed priority read contention, read return with 0xDEAD
    addr = '0; wdata = '0;
    addr[0*AW +: AW] = 22'h10;
    addr[1*AW +: AW] = 22'h20;
    do_cycle(0, 4'b0011, 4'b0000, 0, '0);
    check("fp_cont_gnt", 64'(gnt_f), 64'(4'b0001));
    check("fp_cont_addr", 64'(maddr_f), 64'h10);
    do_cycle(0, 4'b0010, 4'b0000, 1, 64'hDEAD);
    check("rr_ret_vld", 64'(rdv_r), 64'(4'b0001));
    check("rr_ret_data", 64'(rdd_r), 64'hDEAD);
    check("fp_next_gnt", 64'(gnt_f), 64'(4'b0010));

    // Round-robin fairness
    do_cycle(1, 4'b0000, 4'b0000, 0, '0);
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 4'b1111, 4'b0000, 0, '0);
      check("rr_order", 64'(gnt_r), 64'(rr_exp[i]));
    end

    // Tag routing through the 3-deep pipeline
    do_cycle(1, 4'b0000, 4'b0000, 0, '0);
    do_cycle(0, 4'b0100, 4'b0000, 0, '0);
    do_cycle(0, 4'b0001, 4'b0000, 0, '0);
    do_cycle(0, 4'b1000, 4'b0000, 0, '0);
    tag_exp = '{4'b0100, 4'b0001, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 4'b0000, 4'b0000, 1, 64'(i + 7));
      check("fp_tag_route", 64'(rdv_f), 64'(tag_exp[i]));
    end

    // Write produces no return
    addr[1*AW +: AW]  = 22'h5;
    wdata[1*DW +: DW] = 64'h123;
    do_cycle(0, 4'b0010, 4'b0010, 0, '0);
    check("wr_en", 64'(mwe_f), 64'(1));
    check("wr_addr", 64'(maddr_f), 64'h5);
    check("wr_data", 64'(mwd_f), 64'h123);
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 4'b0000, 4'b0000, 1, 64'hBAD);
      check("wr_noret_f", 64'(rdv_f), 64'(0));
      check("wr_noret_r", 64'(rdv_r), 64'(0));
    end

    // Reset mid-flight
    do_cycle(0, 4'b0001, 4'b0000, 0, '0);
    do_cycle(1, 4'b0000, 4'b0000, 1, 64'h55);
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 4'b0000, 4'b0000, 1, 64'h66);
      check("rst_flight_f", 64'(rdv_f), 64'(0));
      check("rst_flight_r", 64'(rdv_r), 64'(0));
    end
    check("rst_flight_ptr", 64'(u_rr.rr_ptr), 64'(0));

`ifdef CRAY_MEM_ARB_STARVE_GUARD_EN
    // Port 1 preempts on its 4th waiting cycle
    do_cycle(1, 4'b0000, 4'b0000, 0, '0);
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 4'b0011, 4'b0000, 0, '0);
      check("starve_gnt", 64'(gnt_f), 64'(rr_exp[i]));
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rand_bus();
      do_cycle($urandom_range(0, 63) == 0, NP'($urandom), NP'($urandom),
               $urandom_range(0, 3) != 0, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cray_mem_arb.md
# cray_mem_arb

Parametrised N-port arbiter that shares the single Cray-1 main-memory port between requesters (functional units, instruction buffers, future I/O channels). Each cycle it selects one requester under fixed-priority or round-robin policy, drives the memory interface from that requester, and returns each read's valid strobe only to the port that issued the read. A RD_LAT-deep tag pipeline supports memories with multi-cycle read latency. The block sits between `cray_top`'s requesters and the external memory pins.

## Interface
- NUM_PORTS, 2: number of requester ports (2..8); port 0 is the highest fixed priority.
- ADDR_W, 22: word-address width.
- DATA_W, 64: word width.
- RD_LAT, 1: cycles from a granted read to `i_mem_vld` (1..8).
- ARB_MODE, 0: arbitration policy; 0 = fixed priority, 1 = round robin.
- STARVE_LIMIT, 15: wait-cycle threshold, used only when the starvation guard is compiled in.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NUM_PORTS  per-port access request; held until granted.
- i_addr  in  NUM_PORTS*ADDR_W  per-port address; port k occupies slice [k*ADDR_W +: ADDR_W].
- i_wr_en  in  NUM_PORTS  per-port write flag; 0 = read.
- i_wr_data  in  NUM_PORTS*DATA_W  per-port write data.
- o_gnt  out  NUM_PORTS  one-hot grant, same cycle as the request.
- o_rd_vld  out  NUM_PORTS  one-hot read-return strobe.
- o_rd_data  out  DATA_W  read data, broadcast to all ports.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wr_data  out  DATA_W  memory write data.
- o_mem_wr_en  out  1  memory write enable.
- o_mem_ce  out  1  memory chip enable.
- i_mem_rd_data  in  DATA_W  memory read data.
- i_mem_vld  in  1  memory read-data valid.

## Operation
- **Grant.** `o_gnt` is combinational from `i_req` and arbiter state, and is at most one-hot. With no requests, `o_gnt` = 0 and `o_mem_ce` = 0.
- **Memory drive.** `o_mem_ce` = |`i_req`. `o_mem_addr`, `o_mem_wr_en` and `o_mem_wr_data` are muxed from the granted port. When no port is granted, addr and wr_data are 0 and wr_en is 0.
- **Fixed priority (ARB_MODE=0).** The lowest-index requesting port wins.
- **Round robin (ARB_MODE=1).** A registered pointer `rr_ptr` names the highest-priority port. The search starts at `rr_ptr` and wraps from NUM_PORTS-1 to 0. After any grant to port k, `rr_ptr` <= (k+1) mod NUM_PORTS. With no grant, `rr_ptr` holds.
- **Tag pipeline.** RD_LAT stages, each holding {vld, port_id}. Stage 0 loads {1, winner} on a granted read and {0, x} otherwise (idle cycle or write). The pipeline shifts every cycle.
- **Read return.**
  - `o_rd_vld[k]` = `i_mem_vld` & last-stage vld & (last-stage port_id == k).
  - `o_rd_data` = `i_mem_rd_data`, passed through combinationally.
  - An `i_mem_vld` with last-stage vld = 0 is dropped: no `o_rd_vld` is asserted.
- **Simultaneous events.** A new grant and a read return in the same cycle are independent; the pipeline shifts and loads in that same cycle.

## Timing
- Grant-to-memory: 0 cycles (combinational).
- Read: grant in cycle t; `o_rd_vld` is asserted in cycle t+RD_LAT, in the same cycle as `i_mem_vld`.
- Back-to-back reads from different ports return in grant order, one per cycle.
- **Reset values.**
  - `rr_ptr` = 0.
  - All tag stages vld = 0.
  - Starvation counters = 0.
  - `o_gnt`, `o_rd_vld` and `o_mem_ce` follow their inputs combinationally; they are 0 while no requests are present.
- **Reset mid-operation.** The tag pipeline is cleared, and in-flight reads return with no `o_rd_vld`.

## Configuration
- Macro: `CRAY_MEM_ARB_STARVE_GUARD_EN`.
- **With the macro defined:**
  - Each port has a 4-bit saturating wait counter.
  - The counter increments while `i_req[k]` & !`o_gnt[k]`, and clears on grant.
  - Any port whose counter is >= STARVE_LIMIT overrides the selected policy. The lowest-index such port wins.
- **Without the macro:** there are no counters, and the policy is pure ARB_MODE.

## Structure
- Package `cray_mem_pkg` holds:
  - `CRAY_ADDR_W` = 22 and `CRAY_WORD_W` = 64.
  - Arbitration mode constants `ARB_FIXED` = 0 and `ARB_RR` = 1.
  - The tag struct {vld, port_id[2:0]}.
- Sub-module `cray_mem_arb_pick`: a combinational rotating-priority one-hot picker with inputs (req vector, start index). Fixed priority uses start index 0.

## Test plan
- **Fixed priority, read contention.** NUM_PORTS=2, ARB_MODE=0, RD_LAT=1; ports 0 and 1 both read, addresses 0x10 and 0x20. Expect `o_gnt`=01 and `o_mem_addr`=0x10. Next cycle `o_rd_vld`=01 with data 0xDEAD. Port 1 is granted on the following cycle.
- **Round robin fairness.** NUM_PORTS=4, ARB_MODE=1; all ports request continuously. Expect grant order 0,1,2,3,0 with no repeats.
- **Tag routing at RD_LAT=3.** Reads granted to ports 2, 0, 3 on consecutive cycles. Expect `o_rd_vld` = 0100, 0001, 1000 on cycles t+3, t+4, t+5.
- **Writes produce no return.** Port 1 writes 0x123 to address 0x5 at RD_LAT=2. Expect `o_mem_wr_en`=1 with that address and data. Drive a spurious `i_mem_vld` two cycles later; `o_rd_vld` must stay 0.
- **Reset mid-flight.** Grant a read, then pulse `rst_n` low one cycle later. Expect `o_rd_vld`=0 when `i_mem_vld` arrives, and `rr_ptr`=0.
- **Starvation guard.** With `CRAY_MEM_ARB_STARVE_GUARD_EN`, ARB_MODE=0, STARVE_LIMIT=3: port 0 requests continuously, port 1 continuously. Expect port 1 granted on its 4th waiting cycle; port 0 resumes the cycle after.
